video_pattern_src: RTL

- Head-of-chain pixel stream source for the video core pipeline. It generates the frame-coordinate stream and a programmable test-pattern RGB, and drives them on a valid/ready interface into the first video core (e.g. the sprite core's src_* port).
- It owns frame sequencing: it starts frames, honours back-pressure, and applies register changes only at frame boundaries.
- Registers are written over a write-only Avalon-MM slave, in the same style as the other video cores.

---
 rtl/video_pattern_src_pkg.sv | 25 ++
 rtl/video_pattern_src_gen.sv | 34 +++
 rtl/video_pattern_src.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/video_pattern_src_pkg.sv
// Shared types and constants for the video core pipeline: frame-coordinate
// bundle, register offsets and test-pattern selector encoding.
package video_pattern_src_pkg;

  // Frame coordinates travelling alongside every pixel.
  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        sof;
    logic        eol;
  } vga_fc_t;

  // Avalon-MM byte offsets of the pattern source registers.
  localparam logic [3:0] CTRL_ADDR   = 4'h0;
  localparam logic [3:0] COLOUR_ADDR = 4'h4;

  // Pattern selector held in ctrl[2:1].
  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_GRAD    = 2'd3
  } pattern_t;

endpackage

// File: rtl/video_pattern_src_gen.sv
// Combinational test-pattern colour for one pixel position. The bar index is
// supplied by the caller's bar-column counter so no divider is needed here.
module video_pattern_gen
  import video_pattern_src_pkg::*;
#(
  parameter int RGB_SIZE = 12
) (
  input  pattern_t              pattern,
  input  logic [RGB_SIZE-1:0]   colour,
  input  logic [10:0]           hc,
  input  logic [10:0]           vc,
  input  logic [2:0]            bar_k,
  output logic [RGB_SIZE-1:0]   rgb
);

  localparam int C = RGB_SIZE / 3;

  // Only a few coordinate bits matter for any one pattern.
  logic unused_coord;
  assign unused_coord = ^{hc, vc};

  // Select the colour for the requested pattern.
  always_comb begin
    rgb = '0;
    case (pattern)
      PAT_SOLID:   rgb = colour;
      PAT_BARS:    rgb = {{C{bar_k[2]}}, {C{bar_k[1]}}, {C{bar_k[0]}}};
      PAT_CHECKER: rgb = (hc[5] ^ vc[5]) ? '1 : '0;
      PAT_GRAD:    rgb = {3{hc[9 -: C]}};
      default:     rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_src.sv
// Head-of-chain pixel source: frame sequencing, back-pressure handling and
// register shadowing, driving a test pattern into the first video core.
//
// Handshake: a beat transfers on a rising clk edge where snk_vld & snk_rdy are
// both high. While snk_vld=1 and snk_rdy=0 the source holds snk_fc/snk_rgb
// stable; snk_vld never drops mid-frame.
module video_pattern_src
  import video_pattern_src_pkg::*;
#(
  parameter int RGB_SIZE = 12,
  parameter int HSIZE    = 640,
  parameter int VSIZE    = 480,
  parameter int BAR_W    = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                avs_write,
  input  logic [3:0]          avs_address,
  input  logic [31:0]         avs_writedata,
  input  logic                snk_rdy,
  output logic                snk_vld,
  output vga_fc_t             snk_fc,
  output logic [RGB_SIZE-1:0] snk_rgb,
  output logic                busy
);

  localparam logic [10:0] H_LAST = 11'(HSIZE - 1);
  localparam logic [10:0] V_LAST = 11'(VSIZE - 1);
  localparam int          BC_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BAR_W - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Shadow registers (written by the bus) and working copies (per frame).
  logic                sh_en;
  pattern_t            sh_pat;
  logic [RGB_SIZE-1:0] sh_col;
  pattern_t            wk_pat;
  logic [RGB_SIZE-1:0] wk_col;

  logic [0:0]      state;
  logic [10:0]     hc_q, vc_q;
  logic [BC_W-1:0] bc_q;
  logic [2:0]      k_q;

  logic [0:0]          nxt_state;
  logic [10:0]         nxt_hc, nxt_vc;
  logic [BC_W-1:0]     nxt_bc;
  logic [2:0]          nxt_k;
  pattern_t            nxt_pat;
  logic [RGB_SIZE-1:0] nxt_col;
  logic [RGB_SIZE-1:0] gen_rgb;

  // Upper write-data bits are not mapped to any register.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Bus writes land in the shadow registers one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en  <= 1'b0;
      sh_pat <= PAT_SOLID;
      sh_col <= '0;
    end else if (avs_write) begin
      if (avs_address == CTRL_ADDR) begin
        sh_en  <= avs_writedata[0];
        sh_pat <= pattern_t'(avs_writedata[2:1]);
      end else if (avs_address == COLOUR_ADDR) begin
        sh_col <= avs_writedata[RGB_SIZE-1:0];
      end
    end
  end

  // Next frame position, bar index and working registers.
  always_comb begin
    nxt_state = state;
    nxt_hc    = hc_q;
    nxt_vc    = vc_q;
    nxt_bc    = bc_q;
    nxt_k     = k_q;
    nxt_pat   = wk_pat;
    nxt_col   = wk_col;
    case (state)
      ST_IDLE: begin
        nxt_hc = '0;
        nxt_vc = '0;
        nxt_bc = '0;
        nxt_k  = '0;
        if (sh_en) begin
          nxt_state = ST_ACTIVE;
          nxt_pat   = sh_pat;
          nxt_col   = sh_col;
        end
      end
      ST_ACTIVE: begin
        if (snk_rdy) begin
          if (hc_q == H_LAST) begin
            nxt_hc = '0;
            nxt_bc = '0;
            nxt_k  = '0;
            if (vc_q == V_LAST) begin
              // Frame boundary: keep streaming only if still enabled.
              nxt_vc = '0;
              if (sh_en) begin
                nxt_pat = sh_pat;
                nxt_col = sh_col;
              end else begin
                nxt_state = ST_IDLE;
              end
            end else begin
              nxt_vc = vc_q + 11'd1;
            end
          end else begin
            nxt_hc = hc_q + 11'd1;
            if (bc_q == BC_LAST) begin
              nxt_bc = '0;
              nxt_k  = (k_q == 3'd7) ? k_q : k_q + 3'd1;
            end else begin
              nxt_bc = bc_q + 1'b1;
            end
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  video_pattern_gen #(
    .RGB_SIZE(RGB_SIZE)
  ) u_gen (
    .pattern (nxt_pat),
    .colour  (nxt_col),
    .hc      (nxt_hc),
    .vc      (nxt_vc),
    .bar_k   (nxt_k),
    .rgb     (gen_rgb)
  );

  // State, counters and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hc_q    <= '0;
      vc_q    <= '0;
      bc_q    <= '0;
      k_q     <= '0;
      wk_pat  <= PAT_SOLID;
      wk_col  <= '0;
      snk_vld <= 1'b0;
      busy    <= 1'b0;
      snk_fc  <= '0;
      snk_rgb <= '0;
    end else begin
      state   <= nxt_state;
      hc_q    <= nxt_hc;
      vc_q    <= nxt_vc;
      bc_q    <= nxt_bc;
      k_q     <= nxt_k;
      wk_pat  <= nxt_pat;
      wk_col  <= nxt_col;
      snk_vld <= (nxt_state == ST_ACTIVE);
      busy    <= (nxt_state == ST_ACTIVE);
      if (nxt_state == ST_ACTIVE) begin
        snk_fc.hc  <= nxt_hc;
        snk_fc.vc  <= nxt_vc;
        snk_fc.sof <= (nxt_hc == 11'd0) && (nxt_vc == 11'd0);
        snk_fc.eol <= (nxt_hc == H_LAST);
        snk_rgb    <= gen_rgb;
      end else begin
        snk_fc  <= '0;
        snk_rgb <= '0;
      end
    end
  end

endmodule
